mem_bist_ctrl: RTL and testbench
================================

// Module: mem_bist_ctrl
// PURPOSE
//  March C- built-in self-test sequencer for the on-chip test memory. Owns the memory's
//  we/addr/wdata pins for a run, checks rdata against expected data, reports pass/fail.
//  Sits between the top-level I/O mux and the memory; top-level muxes its outputs over
//  manual pin control while busy.
// PARAMETERS
//  ADDR_BITS     `ADDR_BITS  memory address width; N = 2**ADDR_BITS words
//  DATA_BITS     `DATA_BITS  memory word width
//  RD_LAT        0           cycles from addr driven to rdata valid (0..2)
//  ERR_CNT_BITS  8           width of saturating error counter
// PORTS
//  clk           in   1             clock
//  rst           in   1             synchronous reset, active high
//  start         in   1             pulse; begins run when idle, ignored when busy
//  pattern       in   DATA_BITS     background word, latched at start
//  mem_we        out  1             memory write enable
//  mem_shift_en  out  1             memory shift enable; constant 0
//  mem_addr      out  ADDR_BITS     memory address
//  mem_wdata     out  DATA_BITS     memory write data
//  mem_rdata     in   DATA_BITS     memory read data
//  busy          out  1             run in progress (incl. read drain)
//  done          out  1             run finished; held until next accepted start or rst
//  fail          out  1             >=1 mismatch in current/last run; sticky
//  err_count     out  ERR_CNT_BITS  mismatch count, saturates at all-ones
// BEHAVIOUR
//  Interface: one clock clk; rst synchronous, active high. All outputs registered.
//  Reset: state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, fail=0, err_count=0.
//  States / elements (B = latched pattern, ~B its inverse):
//   IDLE   : start -> W0_UP next cycle; done/fail/err_count cleared on that edge.
//   W0_UP  : addr 0..N-1 ascending, 1 cycle/addr, write B.
//   RW1_UP : addr 0..N-1 ascending, 2 cycles/addr: READ (expect B) then WRITE ~B.
//   RW0_DN : addr N-1..0 descending, 2 cycles/addr: READ (expect ~B) then WRITE B.
//   R0_UP  : addr 0..N-1 ascending, 1 cycle/addr, read expect B.
//   DRAIN  : RD_LAT cycles letting last compare retire; skipped when RD_LAT=0.
//   DONE   : busy=0, done=1; start -> W0_UP.
//  Element transition on the cycle after the terminal address (N-1 up, 0 down); address
//  counter wraps, no extra idle cycle between elements. Active length = 6N cycles.
//  mem_we=1 only on write cycles; mem_wdata holds last written value on read cycles.
//  Compare: expected word and addr go through an RD_LAT-deep delay line with a valid bit;
//   mem_rdata sampled RD_LAT cycles after the read cycle; mismatch -> fail=1 and
//   err_count+1 (saturating) on the following edge.
//  start during busy or in the start cycle of a run: ignored. rst mid-run: immediate IDLE,
//   all outputs to reset values, in-flight compares discarded.
//  mem_shift_en tied 0: BIST exercises the parallel path only.
// CONFIGURATION
//  MEM_BIST_ERR_CAPTURE_EN defined: extra outputs err_addr[ADDR_BITS], err_exp[DATA_BITS],
//   err_act[DATA_BITS] latch the FIRST mismatch of a run; cleared to 0 at reset and at
//   accepted start; later mismatches do not overwrite. Undefined: ports and regs absent.
// STRUCTURE
//  common.vh: state encodings (MBIST_IDLE..MBIST_DONE), element direction/data constants.
//  Sub-module mem_bist_rd_pipe: RD_LAT-deep delay line of {valid, exp, addr}; pass-through
//   at RD_LAT=0. FSM, address counter and checker stay in mem_bist_ctrl.
// TESTING (ADDR_BITS=4, DATA_BITS=4, RD_LAT=0 unless stated; behavioural memory model)
//  1 fault-free, start pattern=4'hA -> busy exactly 96 cycles, done=1, fail=0, err_count=0.
//  2 addr 5 bit0 stuck-at-1, pattern=0 -> fail=1, err_count=2; capture: err_addr=5,
//    err_exp=0, err_act=1.
//  3 RD_LAT=2, same fault as 2 -> busy 98 cycles, err_count=2, same capture values.
//  4 all bits stuck 0, ERR_CNT_BITS=5, pattern=4'hF -> err_count saturates at 31, fail=1.
//  5 rst asserted at cycle 40 of run -> next cycle all outputs reset; new start runs clean.
//  6 start pulsed at cycles 1 and 50 of a run -> ignored; single 96-cycle run, done once.

Source files
------------

// File: rtl/mem_bist_ctrl_pkg.sv
// Shared types and build defaults for the March C- BIST controller.
// ADDR_BITS / DATA_BITS macros set the default memory geometry when defined.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 4
`endif

package mem_bist_ctrl_pkg;

   localparam int unsigned DEF_ADDR_BITS    = `ADDR_BITS;
   localparam int unsigned DEF_DATA_BITS    = `DATA_BITS;
   localparam int unsigned DEF_RD_LAT       = 0;
   localparam int unsigned DEF_ERR_CNT_BITS = 8;

   // One state per March element, plus bookkeeping states.
   typedef enum logic [2:0] {
      MBIST_IDLE,
      MBIST_W0_UP,
      MBIST_RW1_UP,
      MBIST_RW0_DN,
      MBIST_R0_UP,
      MBIST_DRAIN,
      MBIST_DONE
   } mbist_state_e;

   // A start pulse is only honoured in these states.
   function automatic logic mbist_can_start(input mbist_state_e s);
      return (s == MBIST_IDLE) || (s == MBIST_DONE);
   endfunction

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// Host/memory-side signal bundle for mem_bist_ctrl.
// MEM_BIST_ERR_CAPTURE_EN adds the first-mismatch capture signals.
interface mem_bist_ctrl_if #(
   parameter int unsigned ADDR_BITS    = mem_bist_ctrl_pkg::DEF_ADDR_BITS,
   parameter int unsigned DATA_BITS    = mem_bist_ctrl_pkg::DEF_DATA_BITS,
   parameter int unsigned ERR_CNT_BITS = mem_bist_ctrl_pkg::DEF_ERR_CNT_BITS
);
   logic                    start;
   logic [DATA_BITS-1:0]    pattern;
   logic                    mem_we;
   logic                    mem_shift_en;
   logic [ADDR_BITS-1:0]    mem_addr;
   logic [DATA_BITS-1:0]    mem_wdata;
   logic [DATA_BITS-1:0]    mem_rdata;
   logic                    busy;
   logic                    done;
   logic                    fail;
   logic [ERR_CNT_BITS-1:0] err_count;
`ifdef MEM_BIST_ERR_CAPTURE_EN
   logic [ADDR_BITS-1:0]    err_addr;
   logic [DATA_BITS-1:0]    err_exp;
   logic [DATA_BITS-1:0]    err_act;
`endif

   modport master (
      output start, pattern, mem_rdata,
      input  mem_we, mem_shift_en, mem_addr, mem_wdata, busy, done, fail, err_count
`ifdef MEM_BIST_ERR_CAPTURE_EN
      , err_addr, err_exp, err_act
`endif
   );

   modport slave (
      input  start, pattern, mem_rdata,
      output mem_we, mem_shift_en, mem_addr, mem_wdata, busy, done, fail, err_count
`ifdef MEM_BIST_ERR_CAPTURE_EN
      , err_addr, err_exp, err_act
`endif
   );

endinterface

// File: rtl/mem_bist_rd_pipe.sv
// Delay line of {valid, expected word, address} matching the memory read latency.
// Pure pass-through when RD_LAT is 0.
module mem_bist_rd_pipe #(
   parameter int unsigned RD_LAT    = 0,
   parameter int unsigned ADDR_BITS = 4,
   parameter int unsigned DATA_BITS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic [DATA_BITS-1:0] i_exp,
   input  logic [ADDR_BITS-1:0] i_addr,
   output logic                 o_valid,
   output logic [DATA_BITS-1:0] o_exp,
   output logic [ADDR_BITS-1:0] o_addr
);

   if (RD_LAT == 0) begin : g_bypass
      logic w_unused_clk;
      assign w_unused_clk = i_clk ^ i_rst;
      assign o_valid      = i_valid;
      assign o_exp        = i_exp;
      assign o_addr       = i_addr;
   end else begin : g_delay
      logic [RD_LAT-1:0]    r_valid;
      logic [DATA_BITS-1:0] r_exp  [RD_LAT];
      logic [ADDR_BITS-1:0] r_addr [RD_LAT];

      // Only the valid bits need reset: stale payload is never compared.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_valid <= '0;
         end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < int'(RD_LAT); i++) begin
               r_valid[i] <= r_valid[i-1];
            end
         end
      end

      always_ff @(posedge i_clk) begin
         r_exp[0]  <= i_exp;
         r_addr[0] <= i_addr;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            r_exp[i]  <= r_exp[i-1];
            r_addr[i] <= r_addr[i-1];
         end
      end

      assign o_valid = r_valid[RD_LAT-1];
      assign o_exp   = r_exp[RD_LAT-1];
      assign o_addr  = r_addr[RD_LAT-1];
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST sequencer: drives the memory pins, checks read data, reports pass/fail.
// MEM_BIST_ERR_CAPTURE_EN enables first-mismatch capture (err_addr/err_exp/err_act).
module mem_bist_ctrl #(
   parameter int unsigned ADDR_BITS    = mem_bist_ctrl_pkg::DEF_ADDR_BITS,
   parameter int unsigned DATA_BITS    = mem_bist_ctrl_pkg::DEF_DATA_BITS,
   parameter int unsigned RD_LAT       = mem_bist_ctrl_pkg::DEF_RD_LAT,
   parameter int unsigned ERR_CNT_BITS = mem_bist_ctrl_pkg::DEF_ERR_CNT_BITS
) (
   input logic            i_clk,
   input logic            i_rst,
   mem_bist_ctrl_if.slave io_bus
);
   import mem_bist_ctrl_pkg::*;

   localparam logic [1:0] DRAIN_LAST = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

   mbist_state_e            r_state;
   logic [ADDR_BITS-1:0]    r_addr;
   logic                    r_phase;
   logic [1:0]              r_drain;
   logic [DATA_BITS-1:0]    r_pat;
   logic                    r_we;
   logic [DATA_BITS-1:0]    r_wdata;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_rd_valid;
   logic [DATA_BITS-1:0]    r_rd_exp;
   logic                    r_fail;
   logic [ERR_CNT_BITS-1:0] r_err_cnt;

   logic                    w_last;
   logic                    w_first;
   logic                    w_start_acc;
   logic                    w_pipe_valid;
   logic [DATA_BITS-1:0]    w_pipe_exp;
   logic [ADDR_BITS-1:0]    w_pipe_addr;
   logic                    w_mismatch;

   assign w_last      = (r_addr == '1);
   assign w_first     = (r_addr == '0);
   assign w_start_acc = io_bus.start && mbist_can_start(r_state);

   // Outputs are registered for the cycle being entered, so r_state always names the
   // element whose operation is currently on the memory pins.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= MBIST_IDLE;
         r_addr     <= '0;
         r_phase    <= 1'b0;
         r_drain    <= '0;
         r_pat      <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_exp   <= '0;
      end else begin
         r_we       <= 1'b0;
         r_rd_valid <= 1'b0;
         unique case (r_state)
            MBIST_IDLE, MBIST_DONE: begin
               if (io_bus.start) begin
                  r_state <= MBIST_W0_UP;
                  r_addr  <= '0;
                  r_pat   <= io_bus.pattern;
                  r_we    <= 1'b1;
                  r_wdata <= io_bus.pattern;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            MBIST_W0_UP: begin
               r_addr <= r_addr + 1'b1;
               if (w_last) begin
                  r_state    <= MBIST_RW1_UP;
                  r_phase    <= 1'b0;
                  r_rd_valid <= 1'b1;
                  r_rd_exp   <= r_pat;
               end else begin
                  r_we    <= 1'b1;
                  r_wdata <= r_pat;
               end
            end
            MBIST_RW1_UP: begin
               if (!r_phase) begin
                  r_phase <= 1'b1;
                  r_we    <= 1'b1;
                  r_wdata <= ~r_pat;
               end else begin
                  r_phase    <= 1'b0;
                  r_rd_valid <= 1'b1;
                  if (w_last) begin
                     // Descending element starts where this one ended.
                     r_state  <= MBIST_RW0_DN;
                     r_rd_exp <= ~r_pat;
                  end else begin
                     r_addr   <= r_addr + 1'b1;
                     r_rd_exp <= r_pat;
                  end
               end
            end
            MBIST_RW0_DN: begin
               if (!r_phase) begin
                  r_phase <= 1'b1;
                  r_we    <= 1'b1;
                  r_wdata <= r_pat;
               end else begin
                  r_phase    <= 1'b0;
                  r_rd_valid <= 1'b1;
                  if (w_first) begin
                     r_state  <= MBIST_R0_UP;
                     r_rd_exp <= r_pat;
                  end else begin
                     r_addr   <= r_addr - 1'b1;
                     r_rd_exp <= ~r_pat;
                  end
               end
            end
            MBIST_R0_UP: begin
               r_addr <= r_addr + 1'b1;
               if (!w_last) begin
                  r_rd_valid <= 1'b1;
                  r_rd_exp   <= r_pat;
               end else if (RD_LAT == 0) begin
                  r_state <= MBIST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= MBIST_DRAIN;
                  r_drain <= '0;
               end
            end
            MBIST_DRAIN: begin
               if (r_drain == DRAIN_LAST) begin
                  r_state <= MBIST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_drain <= r_drain + 1'b1;
               end
            end
            default: r_state <= MBIST_IDLE;
         endcase
      end
   end

   mem_bist_rd_pipe #(
      .RD_LAT    (RD_LAT),
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS)
   ) u_rd_pipe (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (r_rd_valid),
      .i_exp   (r_rd_exp),
      .i_addr  (r_addr),
      .o_valid (w_pipe_valid),
      .o_exp   (w_pipe_exp),
      .o_addr  (w_pipe_addr)
   );

   assign w_mismatch = w_pipe_valid && (w_pipe_exp != io_bus.mem_rdata);

   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_acc) begin
         r_fail    <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_mismatch) begin
         r_fail <= 1'b1;
         if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

`ifdef MEM_BIST_ERR_CAPTURE_EN
   logic [ADDR_BITS-1:0] r_err_addr;
   logic [DATA_BITS-1:0] r_err_exp;
   logic [DATA_BITS-1:0] r_err_act;

   // r_fail still low means this is the first mismatch of the run.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_start_acc) begin
         r_err_addr <= '0;
         r_err_exp  <= '0;
         r_err_act  <= '0;
      end else if (w_mismatch && !r_fail) begin
         r_err_addr <= w_pipe_addr;
         r_err_exp  <= w_pipe_exp;
         r_err_act  <= io_bus.mem_rdata;
      end
   end

   assign io_bus.err_addr = r_err_addr;
   assign io_bus.err_exp  = r_err_exp;
   assign io_bus.err_act  = r_err_act;
`else
   logic w_unused_addr;
   assign w_unused_addr = ^w_pipe_addr;
`endif

   assign io_bus.mem_we       = r_we;
   assign io_bus.mem_shift_en = 1'b0;
   assign io_bus.mem_addr     = r_addr;
   assign io_bus.mem_wdata    = r_wdata;
   assign io_bus.busy         = r_busy;
   assign io_bus.done         = r_done;
   assign io_bus.fail         = r_fail;
   assign io_bus.err_count    = r_err_cnt;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (RD_LAT 0 / 8-bit count, RD_LAT 2 / 5-bit count)
// run against a stuck-at memory model and an element-level March C- reference.
module tb_mem_bist_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 4;
   localparam int N     = 16;
   localparam int LAT_A = 0;
   localparam int LAT_B = 2;
   localparam int ECB_A = 8;
   localparam int ECB_B = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start;
   logic [DW-1:0] pattern;

   always #5 clk = ~clk;

   mem_bist_ctrl_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .ERR_CNT_BITS(ECB_A)) if_a ();
   mem_bist_ctrl_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .ERR_CNT_BITS(ECB_B)) if_b ();

   assign if_a.start   = start;
   assign if_b.start   = start;
   assign if_a.pattern = pattern;
   assign if_b.pattern = pattern;

   mem_bist_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .RD_LAT(LAT_A), .ERR_CNT_BITS(ECB_A))
      u_dut_a (.i_clk(clk), .i_rst(rst), .io_bus(if_a));
   mem_bist_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .RD_LAT(LAT_B), .ERR_CNT_BITS(ECB_B))
      u_dut_b (.i_clk(clk), .i_rst(rst), .io_bus(if_b));

   // Stuck-at masks applied on write; stuck-0 dominates.
   logic [DW-1:0] s1 [N];
   logic [DW-1:0] s0 [N];

   function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] w);
      return (w | s1[a]) & ~s0[a];
   endfunction

   logic [DW-1:0] mem_a [N];
   logic [DW-1:0] mem_b [N];
   logic [DW-1:0] rb0, rb1;

   always @(posedge clk) begin
      if (if_a.mem_we) mem_a[if_a.mem_addr] <= faulty(int'(if_a.mem_addr), if_a.mem_wdata);
      if (if_b.mem_we) mem_b[if_b.mem_addr] <= faulty(int'(if_b.mem_addr), if_b.mem_wdata);
      rb0 <= mem_b[if_b.mem_addr];
      rb1 <= rb0;
   end

   assign if_a.mem_rdata = mem_a[if_a.mem_addr];
   assign if_b.mem_rdata = rb1;

   int busy_a = 0, busy_b = 0, we_a = 0, we_b = 0, rise_a = 0, rise_b = 0;
   logic pd_a = 1'b0, pd_b = 1'b0;

   always @(negedge clk) begin
      if (if_a.busy) busy_a++;
      if (if_b.busy) busy_b++;
      if (if_a.busy && if_a.mem_we) we_a++;
      if (if_b.busy && if_b.mem_we) we_b++;
      if (if_a.done && !pd_a) rise_a++;
      if (if_b.done && !pd_b) rise_b++;
      pd_a = if_a.done;
      pd_b = if_b.done;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: March C- on an abstract faulty array, element by element.
   logic [DW-1:0] mdl_mem [N];
   int            mdl_errs;
   int            mdl_f_addr;
   int            mdl_f_exp;
   int            mdl_f_act;

   task automatic mdl_read(input int a, input logic [DW-1:0] e);
      if (mdl_mem[a] != e) begin
         if (mdl_errs == 0) begin
            mdl_f_addr = a;
            mdl_f_exp  = int'(e);
            mdl_f_act  = int'(mdl_mem[a]);
         end
         mdl_errs++;
      end
   endtask

   task automatic mdl_march(input logic [DW-1:0] b);
      mdl_errs = 0; mdl_f_addr = 0; mdl_f_exp = 0; mdl_f_act = 0;
      for (int a = 0; a < N; a++) mdl_mem[a] = faulty(a, b);
      for (int a = 0; a < N; a++) begin mdl_read(a, b); mdl_mem[a] = faulty(a, ~b); end
      for (int a = N - 1; a >= 0; a--) begin mdl_read(a, ~b); mdl_mem[a] = faulty(a, b); end
      for (int a = 0; a < N; a++) mdl_read(a, b);
   endtask

   task automatic clear_faults();
      for (int a = 0; a < N; a++) begin s1[a] = '0; s0[a] = '0; end
   endtask

   task automatic check_run(input string dn, input int lat, input int ecb, input int nbusy,
                            input int nwe, input int nrise, input logic o_done,
                            input logic o_busy, input logic o_fail, input int cnt,
                            input logic shift);
      int sat;
      sat = (1 << ecb) - 1;
      check_eq({dn, "_busy_cycles"}, nbusy, 6 * N + lat);
      check_eq({dn, "_writes"}, nwe, 3 * N);
      check_eq({dn, "_done_pulses"}, nrise, 1);
      check_eq({dn, "_done"}, int'(o_done), 1);
      check_eq({dn, "_busy_end"}, int'(o_busy), 0);
      check_eq({dn, "_fail"}, int'(o_fail), int'(mdl_errs != 0));
      check_eq({dn, "_err_count"}, cnt, (mdl_errs > sat) ? sat : mdl_errs);
      check_eq({dn, "_shift_en"}, int'(shift), 0);
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_a_we"}, int'(if_a.mem_we), 0);
      check_eq({tag, "_a_addr"}, int'(if_a.mem_addr), 0);
      check_eq({tag, "_a_wdata"}, int'(if_a.mem_wdata), 0);
      check_eq({tag, "_a_busy"}, int'(if_a.busy), 0);
      check_eq({tag, "_a_done"}, int'(if_a.done), 0);
      check_eq({tag, "_a_fail"}, int'(if_a.fail), 0);
      check_eq({tag, "_a_cnt"}, int'(if_a.err_count), 0);
      check_eq({tag, "_b_busy"}, int'(if_b.busy), 0);
      check_eq({tag, "_b_done"}, int'(if_b.done), 0);
      check_eq({tag, "_b_fail"}, int'(if_b.fail), 0);
      check_eq({tag, "_b_cnt"}, int'(if_b.err_count), 0);
`ifdef MEM_BIST_ERR_CAPTURE_EN
      check_eq({tag, "_a_cap_addr"}, int'(if_a.err_addr), 0);
      check_eq({tag, "_b_cap_act"}, int'(if_b.err_act), 0);
`endif
   endtask

   task automatic run_march(input logic [DW-1:0] pat, input bit glitch, input bit clean);
      int ba, bb, wa, wb, ra, rb, cyc, bad;
      ba = busy_a; bb = busy_b; wa = we_a; wb = we_b; ra = rise_a; rb = rise_b;
      mdl_march(pat);
      @(posedge clk); #1;
      start = 1'b1; pattern = pat;
      @(posedge clk); #1;
      if (glitch) begin
         // Hold start through the first two run cycles with a different pattern.
         pattern = ~pat;
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (glitch) begin
         repeat (48) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0; pattern = pat;
      end
      cyc = 0;
      while (!(if_a.done && if_b.done) && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("run_completes", int'(if_a.done && if_b.done), 1);
      @(posedge clk); #1;
      check_run("a", LAT_A, ECB_A, busy_a - ba, we_a - wa, rise_a - ra, if_a.done, if_a.busy,
                if_a.fail, int'(if_a.err_count), if_a.mem_shift_en);
      check_run("b", LAT_B, ECB_B, busy_b - bb, we_b - wb, rise_b - rb, if_b.done, if_b.busy,
                if_b.fail, int'(if_b.err_count), if_b.mem_shift_en);
`ifdef MEM_BIST_ERR_CAPTURE_EN
      check_eq("a_cap_addr", int'(if_a.err_addr), mdl_f_addr);
      check_eq("a_cap_exp", int'(if_a.err_exp), mdl_f_exp);
      check_eq("a_cap_act", int'(if_a.err_act), mdl_f_act);
      check_eq("b_cap_addr", int'(if_b.err_addr), mdl_f_addr);
      check_eq("b_cap_exp", int'(if_b.err_exp), mdl_f_exp);
      check_eq("b_cap_act", int'(if_b.err_act), mdl_f_act);
`endif
      if (clean) begin
         bad = 0;
         for (int a = 0; a < N; a++) begin
            if (mem_a[a] != pat) bad++;
            if (mem_b[a] != pat) bad++;
         end
         check_eq("final_contents_bad_words", bad, 0);
      end
   endtask

   initial begin
      int nf, fa;
      logic [DW-1:0] rp;
      clear_faults();
      start = 1'b0;
      pattern = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset("reset");
      rst = 1'b0;

      run_march(4'hA, 1'b0, 1'b1);

      s1[5] = 4'h1;
      run_march(4'h0, 1'b0, 1'b0);

      clear_faults();
      for (int a = 0; a < N; a++) s0[a] = '1;
      run_march(4'hF, 1'b0, 1'b0);

      // Reset mid-run after the addr-5 fault has already been flagged.
      clear_faults();
      s1[5] = 4'h1;
      @(posedge clk); #1;
      start = 1'b1; pattern = 4'h0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (39) @(posedge clk);
      #1 check_eq("pre_reset_fail", int'(if_a.fail), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset("mid_reset");
      rst = 1'b0;
      clear_faults();
      run_march(4'h5, 1'b0, 1'b1);

      run_march(4'h6, 1'b1, 1'b1);

      for (int r = 0; r < 6; r++) begin
         clear_faults();
         rp = DW'($urandom);
         nf = $urandom_range(0, 3);
         for (int k = 0; k < nf; k++) begin
            fa = $urandom_range(0, N - 1);
            s1[fa] = DW'($urandom);
            s0[fa] = DW'($urandom);
         end
         run_march(rp, 1'b0, nf == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
